// File: rtl/btn_debounce_rate_sel_pkg.sv
// Shared types and helpers for the button debouncer / rate selector.
// State encoding plus a millisecond-to-cycle conversion.
package btn_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        HELD,
        DEB_REL
    } state_e;

    function automatic int unsigned ms_to_cycles(
        input int unsigned clk_hz,
        input int unsigned ms
    );
        return clk_hz / 1000 * ms;
    endfunction

endpackage

// File: rtl/btn_debounce_rate_sel_sync_2ff.sv
// Two-flop synchronizer for the raw asynchronous button input.
// Cleared by the same synchronous active-low reset as the rest of the block.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_d, meta_q;
    logic sync_d, sync_q;

    // Shift the input one stage per clock
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer stages, cleared while rst is low
    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/btn_debounce_rate_sel.sv
// Button debouncer emitting press/release pulses and a wrapping 2-bit rate index.
// Optional long-press detection is built when LONG_PRESS_EN is defined.
module btn_debounce_rate_sel
    import btn_debounce_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned LONG_MS     = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic [1:0] rate_sel,
    output logic       long_pulse
);

    localparam int unsigned DB_CYCLES   = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
    localparam int unsigned LONG_CYCLES = ms_to_cycles(CLK_HZ, LONG_MS);
    localparam int unsigned DB_W =
        (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    // Elaboration-time sanity: long press must outlast the debounce window
    if (LONG_CYCLES <= DB_CYCLES) begin : g_bad_long
        $error("LONG_MS must exceed DEBOUNCE_MS");
    end

    logic btn_s;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (btn_s)
    );

    state_e          state_d, state_q;
    logic [DB_W-1:0] cnt_d, cnt_q;
    logic [1:0]      rate_d, rate_q;
    logic            press_d, press_q;
    logic            rel_d, rel_q;
    logic            level_d, level_q;

`ifdef LONG_PRESS_EN
    localparam int unsigned LONG_W =
        (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

    logic [LONG_W-1:0] lcnt_d, lcnt_q;
    logic              fired_d, fired_q;
    logic              long_d, long_q;
`endif

    // Next-state, debounce counter, pulses and rate index
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rate_d  = rate_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d = DEB_PRESS;
                    cnt_d   = '0;
                end
            end
            DEB_PRESS: begin
                if (!btn_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    press_d = 1'b1;
                    rate_d  = rate_q + 2'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_d = DEB_REL;
                    cnt_d   = '0;
                end
            end
            DEB_REL: begin
                if (btn_s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    rel_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        level_d = (state_d == HELD) || (state_d == DEB_REL);
`ifdef LONG_PRESS_EN
        // Hold timer restarts only on a fresh press, pauses in DEB_REL
        lcnt_d  = lcnt_q;
        fired_d = fired_q;
        long_d  = 1'b0;
        if (state_q == DEB_PRESS && state_d == HELD) begin
            lcnt_d  = '0;
            fired_d = 1'b0;
        end else if (state_q == HELD && !fired_q) begin
            if (lcnt_q == LONG_LAST) begin
                long_d  = 1'b1;
                fired_d = 1'b1;
                rate_d  = 2'd0;
            end else begin
                lcnt_d = lcnt_q + 1'b1;
            end
        end
`endif
    end

    // FSM and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rate_q  <= 2'd0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rate_q  <= rate_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            level_q <= level_d;
        end
    end

`ifdef LONG_PRESS_EN
    // Long-press timer state
    always_ff @(posedge clk) begin
        if (!rst) begin
            lcnt_q  <= '0;
            fired_q <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            lcnt_q  <= lcnt_d;
            fired_q <= fired_d;
            long_q  <= long_d;
        end
    end

    assign long_pulse = long_q;
`else
    assign long_pulse = 1'b0;
`endif

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = rel_q;
    assign rate_sel      = rate_q;

endmodule

// File: tb/tb_btn_debounce_rate_sel.sv
// Directed bench for btn_debounce_rate_sel with an event scoreboard.
// Build with LONG_PRESS_EN defined to exercise long-press detection.
module tb_btn_debounce_rate_sel;

    logic       clk;
    logic       rst;
    logic       btn_in;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic [1:0] rate_sel;
    logic       long_pulse;

    btn_debounce_rate_sel #(
        .CLK_HZ      (1000),
        .DEBOUNCE_MS (4),
        .LONG_MS     (20)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_in        (btn_in),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .rate_sel      (rate_sel),
        .long_pulse    (long_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {EV_PRESS, EV_REL, EV_LONG} ev_e;
    typedef struct {
        int         cyc;
        ev_e        kind;
        logic [1:0] rate;
    } ev_t;

    ev_t        sb[$];
    int         cyc        = 0;
    int         n_cmp      = 0;
    int         n_err      = 0;
    logic [1:0] model_rate = 2'd0;
    logic [1:0] exp_rate   = 2'd0;
    logic       exp_level  = 1'b0;

    localparam int LAT = 7;

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
                   tag, cyc, obs, exp);
        end
    endtask

    task automatic push(input int dly, input ev_e k);
        if (k == EV_PRESS) model_rate = model_rate + 2'd1;
        if (k == EV_LONG)  model_rate = 2'd0;
        sb.push_back('{cyc: cyc + dly, kind: k, rate: model_rate});
    endtask

    task automatic tick();
        logic r;
        logic e_press, e_rel, e_long;
        ev_t  e;
        r = rst;
        @(posedge clk);
        #1;
        cyc++;
        if (!r) begin
            exp_rate  = 2'd0;
            exp_level = 1'b0;
            sb.delete();
        end
        e_press = 1'b0;
        e_rel   = 1'b0;
        e_long  = 1'b0;
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            case (e.kind)
                EV_PRESS: begin e_press = 1'b1; exp_level = 1'b1; end
                EV_REL:   begin e_rel   = 1'b1; exp_level = 1'b0; end
                default:  e_long = 1'b1;
            endcase
            exp_rate = e.rate;
        end
        chk("press_pulse",   {3'b0, press_pulse},   {3'b0, e_press});
        chk("release_pulse", {3'b0, release_pulse}, {3'b0, e_rel});
        chk("long_pulse",    {3'b0, long_pulse},    {3'b0, e_long});
        chk("btn_level",     {3'b0, btn_level},     {3'b0, exp_level});
        chk("rate_sel",      {2'b0, rate_sel},      {2'b0, exp_rate});
    endtask

    task automatic do_reset(input int n, input logic b);
        rst        = 1'b0;
        btn_in     = b;
        model_rate = 2'd0;
        repeat (n) tick();
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b0;
        btn_in = 1'b1;

        // 1: reset with button held, then re-debounce after release
        do_reset(3, 1'b1);
        push(LAT, EV_PRESS);
        repeat (10) tick();
        btn_in = 1'b0;
        push(LAT, EV_REL);
        repeat (10) tick();

        // 2: bouncing press, then bouncing release
        btn_in = 1'b1; tick(); tick();
        btn_in = 1'b0; tick();
        btn_in = 1'b1;
        push(LAT, EV_PRESS);
        repeat (12) tick();
        btn_in = 1'b0; tick(); tick();
        btn_in = 1'b1; tick();
        btn_in = 1'b0;
        push(LAT, EV_REL);
        repeat (12) tick();

        // 3: five clean presses, rate wraps 1,2,3,0,1
        do_reset(2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            btn_in = 1'b1;
            push(LAT, EV_PRESS);
            repeat (10) tick();
            btn_in = 1'b0;
            push(LAT, EV_REL);
            repeat (10) tick();
        end

        // 4: reset while debouncing a press (cnt == 2)
        btn_in = 1'b1;
        repeat (5) tick();
        do_reset(2, 1'b0);
        repeat (10) tick();

        // 5: single-cycle glitch is rejected
        btn_in = 1'b1; tick();
        btn_in = 1'b0;
        repeat (10) tick();

        // 6: 30-cycle hold
        btn_in = 1'b1;
        push(LAT, EV_PRESS);
`ifdef LONG_PRESS_EN
        push(LAT + 20, EV_LONG);
`endif
        repeat (30) tick();
        btn_in = 1'b0;
        push(LAT, EV_REL);
        repeat (12) tick();

        chk("sb_drained", 4'(sb.size()), 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
